// File: rtl/simon_tone_sched.sv
// Tone sequencer/arbiter for the Simon game: plays timed single tones or canned
// melodies on one frequency word, with its own millisecond timebase.
module simon_tone_sched #(
  parameter int FREQ_W = 10,
  parameter int DUR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ticks_per_milli,
  input  logic              tone_valid,
  input  logic [FREQ_W-1:0] tone_freq,
  input  logic [DUR_W-1:0]  tone_ms,
  output logic              tone_ready,
  input  logic              melody_start,
  input  logic              melody_id,
  input  logic              abort,
  output logic [FREQ_W-1:0] freq,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, TONE, MEL_NOTE, MEL_TREM} state_t;

  localparam logic [DUR_W:0] SUCC_NOTE_MS = (DUR_W+1)'(150);
  localparam logic [DUR_W:0] OVER_NOTE_MS = (DUR_W+1)'(300);
  localparam logic [DUR_W:0] TREM_MS      = (DUR_W+1)'(1000);

  state_t            state_q, state_d;
  logic [15:0]       tick_q, tick_d;
  logic [DUR_W:0]    ms_q, ms_d;
  logic [2:0]        idx_q, idx_d;
  logic [FREQ_W-1:0] tfreq_q, tfreq_d;
  logic [DUR_W-1:0]  tms_q, tms_d;
  logic              mid_q, mid_d;
  logic              done_q, done_d;

  logic [15:0]       tick_lim;
  logic              ms_wrap;
  logic [DUR_W:0]    ms_next;
  logic [15:0]       tick_adv;
  logic [DUR_W:0]    ms_adv;
  logic [DUR_W:0]    note_ms;
  logic              last_note;

  function automatic logic [FREQ_W-1:0] note_freq(input logic id, input logic [2:0] idx);
    logic [FREQ_W-1:0] f;
    f = '0;
    case ({id, idx})
      4'b0_000: f = FREQ_W'(330);
      4'b0_001: f = FREQ_W'(392);
      4'b0_010: f = FREQ_W'(659);
      4'b0_011: f = FREQ_W'(523);
      4'b0_100: f = FREQ_W'(587);
      4'b0_101: f = FREQ_W'(784);
      4'b1_000: f = FREQ_W'(622);
      4'b1_001: f = FREQ_W'(587);
      4'b1_010: f = FREQ_W'(554);
      4'b1_011: f = FREQ_W'(523);
      default:  f = '0;
    endcase
    return f;
  endfunction

  // A zero tick rate behaves as one tick per ms; >= lets a shrinking rate take effect at once.
  always_comb begin
    tick_lim  = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    ms_wrap   = (tick_q >= tick_lim);
    ms_next   = ms_q + 1'b1;
    tick_adv  = ms_wrap ? 16'd0 : tick_q + 16'd1;
    ms_adv    = ms_wrap ? ms_next : ms_q;
    note_ms   = mid_q ? OVER_NOTE_MS : SUCC_NOTE_MS;
    last_note = mid_q ? (idx_q == 3'd3) : (idx_q == 3'd6);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    idx_d   = idx_q;
    tfreq_d = tfreq_q;
    tms_d   = tms_q;
    mid_d   = mid_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      tick_d  = '0;
      ms_d    = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (melody_start) begin
            state_d = MEL_NOTE;
            mid_d   = melody_id;
            idx_d   = '0;
            tick_d  = '0;
            ms_d    = '0;
          end else if (tone_valid) begin
            state_d = TONE;
            tfreq_d = tone_freq;
            tms_d   = tone_ms;
            tick_d  = '0;
            ms_d    = '0;
          end
        end
        TONE: begin
          tick_d = tick_adv;
          ms_d   = ms_adv;
          if (ms_wrap && (tms_q != '0) && (ms_next == {1'b0, tms_q})) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tick_d  = '0;
            ms_d    = '0;
          end
        end
        MEL_NOTE: begin
          tick_d = tick_adv;
          ms_d   = ms_adv;
          if (ms_wrap && (ms_next == note_ms)) begin
            tick_d = '0;
            ms_d   = '0;
            if (!last_note) begin
              idx_d = idx_q + 3'd1;
            end else if (mid_q) begin
              state_d = MEL_TREM;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              idx_d   = '0;
            end
          end
        end
        MEL_TREM: begin
          tick_d = tick_adv;
          ms_d   = ms_adv;
          if (ms_wrap && (ms_next == TREM_MS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tick_d  = '0;
            ms_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      ms_q    <= '0;
      idx_q   <= '0;
      tfreq_q <= '0;
      tms_q   <= '0;
      mid_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      idx_q   <= idx_d;
      tfreq_q <= tfreq_d;
      tms_q   <= tms_d;
      mid_q   <= mid_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registered state only, so reset silences the generator without a clock.
  always_comb begin
    freq = '0;
    case (state_q)
      TONE:     freq = tfreq_q;
      MEL_NOTE: freq = note_freq(mid_q, idx_q);
      MEL_TREM: freq = FREQ_W'(507) + FREQ_W'(ms_q[4:0]);
      default:  freq = '0;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign tone_ready = rst_n && (state_q == IDLE) && !melody_start;

endmodule

// File: tb/tb_simon_tone_sched.sv
// Scoreboard bench for simon_tone_sched: expected per-cycle freq/busy/done
// samples are queued with each stimulus and compared just after each clock edge.
module tb_simon_tone_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ticks_per_milli = 16'd2;
  logic        tone_valid = 1'b0;
  logic [9:0]  tone_freq = '0;
  logic [9:0]  tone_ms = '0;
  logic        tone_ready;
  logic        melody_start = 1'b0;
  logic        melody_id = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  freq;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [9:0] f;
    logic       b;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   succ[7] = '{330, 392, 659, 523, 587, 784, 0};
  int   over[4] = '{622, 587, 554, 523};

  simon_tone_sched #(.FREQ_W(10), .DUR_W(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ticks_per_milli(ticks_per_milli),
    .tone_valid(tone_valid),
    .tone_freq(tone_freq),
    .tone_ms(tone_ms),
    .tone_ready(tone_ready),
    .melody_start(melody_start),
    .melody_id(melody_id),
    .abort(abort),
    .freq(freq),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic tv, input int tf, input int tm,
                               input logic ms, input logic mid, input logic ab);
    tone_valid   = tv;
    tone_freq    = 10'(tf);
    tone_ms      = 10'(tm);
    melody_start = ms;
    melody_id    = mid;
    abort        = ab;
  endtask

  task automatic pushExp(input int f, input logic b, input logic d, input int n);
    exp_t e;
    e.f = 10'(f);
    e.b = b;
    e.d = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Requests live for one edge only; the sample after that edge is popped and compared.
  task automatic drainQueue(input string tag);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      tone_valid   = 1'b0;
      melody_start = 1'b0;
      abort        = 1'b0;
      e = exp_q.pop_front();
      checkOutput($sformatf("%s_freq[%0d]", tag, cyc), 32'(freq), 32'(e.f));
      checkOutput($sformatf("%s_busy[%0d]", tag, cyc), 32'(busy), 32'(e.b));
      checkOutput($sformatf("%s_done[%0d]", tag, cyc), 32'(done), 32'(e.d));
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    #1;
    checkOutput("rst_freq", 32'(freq), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ready", 32'(tone_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_ready", 32'(tone_ready), 32'd1);

    $display("[TB] single tone 262 Hz, 3 ms");
    applyStimulus(1'b1, 262, 3, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("tone_ready_idle", 32'(tone_ready), 32'd1);
    pushExp(262, 1'b1, 1'b0, 6);
    pushExp(0, 1'b0, 1'b1, 1);
    pushExp(0, 1'b0, 1'b0, 1);
    drainQueue("tone");

    $display("[TB] simultaneous tone and success melody");
    applyStimulus(1'b1, 100, 2, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("simul_ready", 32'(tone_ready), 32'd0);
    for (int i = 0; i < 7; i++) pushExp(succ[i], 1'b1, 1'b0, 300);
    pushExp(0, 1'b0, 1'b1, 1);
    pushExp(0, 1'b0, 1'b0, 1);
    drainQueue("succ");

    $display("[TB] game-over melody with trembling tail");
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pushExp(over[i], 1'b1, 1'b0, 600);
    for (int m = 0; m < 1000; m++) pushExp(507 + (m % 32), 1'b1, 1'b0, 2);
    pushExp(0, 1'b0, 1'b1, 1);
    pushExp(0, 1'b0, 1'b0, 1);
    drainQueue("over");

    $display("[TB] sustained tone, busy rejection and abort");
    applyStimulus(1'b1, 784, 0, 1'b0, 1'b0, 1'b0);
    pushExp(784, 1'b1, 1'b0, 10);
    drainQueue("sust");
    applyStimulus(1'b1, 100, 1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("busy_ready", 32'(tone_ready), 32'd0);
    pushExp(784, 1'b1, 1'b0, 5);
    drainQueue("ignore");
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    pushExp(0, 1'b0, 1'b0, 3);
    drainQueue("abort");
    applyStimulus(1'b1, 500, 2, 1'b0, 1'b0, 1'b1);
    pushExp(0, 1'b0, 1'b0, 3);
    drainQueue("abort_idle");

    $display("[TB] degenerate timebase");
    ticks_per_milli = 16'd0;
    applyStimulus(1'b1, 440, 5, 1'b0, 1'b0, 1'b0);
    pushExp(440, 1'b1, 1'b0, 5);
    pushExp(0, 1'b0, 1'b1, 1);
    pushExp(0, 1'b0, 1'b0, 1);
    drainQueue("tpm0");
    ticks_per_milli = 16'd2;

    $display("[TB] asynchronous reset mid-melody");
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    pushExp(330, 1'b1, 1'b0, 1);
    drainQueue("rst_mel");
    n = int'($urandom_range(1899, 10));
    repeat (n) @(posedge clk);
    #1;
    checkOutput("pre_rst_freq", 32'(freq), 32'(succ[n / 300]));
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_freq", 32'(freq), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_ready", 32'(tone_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(tone_ready), 32'd1);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_freq", 32'(freq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_tone_sched.md
Name: simon_tone_sched

Overview:
- Sequencer and arbiter in front of the square-wave tone generator in the Simon game.
- Serves two requesters that must never drive the tone generator at the same time:
  - single timed game tones, for button presses and sequence playback;
  - canned melodies: the level-success jingle and the game-over phrase with its trembling tail.
- Keeps its own millisecond timebase and drives a single 10-bit frequency word to the tone generator.
- Reports busy/done so the game FSM no longer has to count notes itself.

Parameters:
- FREQ_W, 10, width of frequency words in Hz.
- DUR_W, 10, width of duration fields in milliseconds.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ticks_per_milli  input  16  clk cycles per millisecond. Value 0 is treated as 1.
- tone_valid  input  1  single-tone request.
- tone_freq  input  FREQ_W  tone frequency in Hz.
- tone_ms  input  DUR_W  tone duration in ms. 0 = sustain until abort.
- tone_ready  output  1  high when idle and no melody request is winning this cycle.
- melody_start  input  1  melody request; sampled only when idle.
- melody_id  input  1  0 = success, 1 = game-over.
- abort  input  1  stop any activity immediately.
- freq  output  FREQ_W  frequency to the tone generator. 0 = silent.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a tone or melody completes naturally. Never pulses on abort.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; freq=0, busy=0, done=0;
  - all counters and latches cleared;
  - tone_ready=0 while rst_n is low.
- Millisecond timebase:
  - tick counter runs 0..max(ticks_per_milli,1)-1; ms_count increments on wrap.
  - Both are cleared on every note load, so an N-ms note lasts exactly N*ticks_per_milli cycles.
  - ms_count is DUR_W+1 bits so that 1000 fits.
- States: IDLE, TONE, MEL_NOTE, MEL_TREM.
- IDLE:
  - freq=0.
  - If melody_start=1, the melody is accepted: melody beats tone when both are asserted in the same cycle.
  - Otherwise, if tone_valid and tone_ready, the tone is accepted.
  - tone_ready = IDLE & !melody_start.
- Acceptance latency:
  - request sampled at edge k; state and freq change at edge k; freq is valid from cycle k+1.
  - tone_freq, tone_ms and melody_id are latched at acceptance.
- TONE:
  - freq=latched tone_freq.
  - When ms_count reaches tone_ms (nonzero), at that edge: freq=0, done=1, go to IDLE.
  - tone_ms=0 sustains indefinitely.
  - A tone_freq of 0 plays silence for the stated duration.
- MEL_NOTE uses a 3-bit note index:
  - Success melody: 330, 392, 659, 523, 587, 784, 0, each 150 ms. After the 7th note: done, go to IDLE. Total 1050 ms.
  - Game-over melody: 622, 587, 554, 523, each 300 ms, then go to MEL_TREM with timers cleared.
- MEL_TREM:
  - freq = 507 + ms_count[4:0], i.e. 523 − 16 + 0..31, recomputed every ms.
  - At ms_count=1000: freq=0, done=1, go to IDLE.
- Abort:
  - abort=1 in any state: next edge goes to IDLE with freq=0, no done pulse, note index cleared.
  - Abort has priority over acceptance in the same cycle: nothing is accepted.
- Requests while busy:
  - tone_valid and melody_start are ignored; they are not queued.
  - The requester must hold tone_valid until tone_ready.
- done and acceptance:
  - done is asserted in the cycle after the completing edge, with state=IDLE.
  - A new request may be accepted in that same cycle.
- Arithmetic:
  - Table and frequency values are unsigned FREQ_W.
  - The trembling sum stays ≤ 538, so there is no overflow.
  - ms and tick counters never wrap during legal operation; tick comparison uses the full 16 bits.
- ticks_per_milli changes mid-note take effect at the next tick-counter comparison. No reset is required.

Test Plan:
All scenarios use ticks_per_milli=2 unless stated.
- Reset mid-melody: start success melody, drop rst_n asynchronously at a random cycle → freq=0, busy=0, done=0 immediately with no clock edge; tone_ready=1 after release.
- Tone timing: tone_valid, freq 262, ms 3 in IDLE → freq=262 for exactly 6 cycles starting the cycle after acceptance, then freq=0, one done pulse, busy=0.
- Simultaneous requests: tone_valid and melody_start(id=0) in the same IDLE cycle → tone_ready=0 that cycle; success sequence 330, 392, 659, 523, 587, 784, 0, each held 300 cycles; done after 2100 cycles; tone not played.
- Game-over: melody_start id=1 → 622, 587, 554, 523 each for 600 cycles, then freq steps 507..538 every 2 cycles and wraps to 507 after 32 ms; freq=0 and done at 2000 cycles into the trembling tail.
- Abort and busy rejection:
  - during a sustained tone (ms=0, freq 784), pulse tone_valid and melody_start → ignored;
  - then abort → freq=0 next edge, no done, IDLE;
  - abort together with tone_valid in IDLE → nothing accepted.
- Degenerate timebase: ticks_per_milli=0 with tone ms=5 → tone lasts exactly 5 cycles; done fires once.
